// File: rtl/opb_sw_reg_pkg.sv
// Shared types and helpers for the OPB software-register family
// (ppc2simulink write registers and simulink2ppc status registers).
package opb_sw_reg_pkg;

    localparam int OPB_DWIDTH     = 32;
    localparam int NUM_BYTE_LANES = OPB_DWIDTH / 8;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } opb_state_e;

    // Mirrors bit indices: out[i] = in[31-i]. Moves a word between OPB
    // big-endian numbering and the index-preserving internal/user view.
    function automatic logic [31:0] bit_reverse32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = x[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/opb_slave_decode.sv
// OPB slave window decode plus the IDLE/ACK handshake FSM, shareable by
// every OPB software register.
module opb_slave_decode
    import opb_sw_reg_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
    parameter int          C_OPB_AWIDTH = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [0:31] abus_i,
    input  logic        select_i,
    output logic        start_o,
    output logic        off0_o,
    output logic        ack_o
);

    opb_state_e  state_q, state_d;
    logic [32:0] lo_diff, hi_diff;
    logic        in_window, hit;

    // Borrow-out range checks stay valid when the base is zero.
    assign lo_diff   = {1'b0, abus_i} - {1'b0, C_BASEADDR};
    assign hi_diff   = {1'b0, C_HIGHADDR} - {1'b0, abus_i};
    assign in_window = !lo_diff[32] && !hi_diff[32];
    assign hit       = select_i && in_window;

    assign off0_o  = (abus_i[C_OPB_AWIDTH-8 +: 6] == 6'd0);
    assign start_o = (state_q == IDLE) && hit;
    assign ack_o   = (state_q == ACK);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ACK ignores select so a master slow to drop it gets exactly one ack.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hit) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/opb_register_ppc2simulink.sv
// PowerPC-writable 32-bit register on OPB, presented to fabric with a
// one-cycle update strobe on each byte-enabled write.
module opb_register_ppc2simulink
    import opb_sw_reg_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter string       C_FAMILY     = "virtex5",
    parameter logic [31:0] C_DEFAULT    = 32'h0000_0000
) (
    input  logic        OPB_Clk,
    input  logic        OPB_Rst,
    input  logic [0:31] OPB_ABus,
    input  logic [0:3]  OPB_BE,
    input  logic [0:31] OPB_DBus,
    input  logic        OPB_RNW,
    input  logic        OPB_select,
    input  logic        OPB_seqAddr,
    output logic [0:31] Sl_DBus,
    output logic        Sl_xferAck,
    output logic        Sl_errAck,
    output logic        Sl_retry,
    output logic        Sl_toutSup,
    output logic [31:0] user_data_out,
    output logic        user_data_valid
);

    logic        start, off0, ack;
    logic        wr_hit, rd_hit;
    logic [31:0] wdata;
    // Internal storage is index-preserving: data_q[i] holds OPB bit i.
    logic [31:0] data_q, data_d;
    logic [31:0] rdata_q, rdata_d;
    logic        valid_q, valid_d;
    logic        unused_ok;

    opb_slave_decode #(
        .C_BASEADDR   (C_BASEADDR),
        .C_HIGHADDR   (C_HIGHADDR),
        .C_OPB_AWIDTH (C_OPB_AWIDTH)
    ) u_decode (
        .clk_i    (OPB_Clk),
        .rst_i    (OPB_Rst),
        .abus_i   (OPB_ABus),
        .select_i (OPB_select),
        .start_o  (start),
        .off0_o   (off0),
        .ack_o    (ack)
    );

    assign wdata  = bit_reverse32(OPB_DBus);
    assign wr_hit = start && off0 && !OPB_RNW;
    assign rd_hit = start && off0 && OPB_RNW;

    always_comb begin
        data_d = data_q;
        if (wr_hit) begin
            for (int k = 0; k < NUM_BYTE_LANES; k++) begin
                if (OPB_BE[k]) data_d[8*k +: 8] = wdata[8*k +: 8];
            end
        end
    end

    // Read data is loaded only on the entering edge, so it is zero outside ACK.
    assign rdata_d = rd_hit ? bit_reverse32(data_q) : 32'h0;
    assign valid_d = wr_hit && (|OPB_BE);

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            data_q  <= bit_reverse32(C_DEFAULT);
            rdata_q <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
        end
    end

    assign Sl_DBus         = rdata_q;
    assign Sl_xferAck      = ack;
    assign Sl_errAck       = 1'b0;
    assign Sl_retry        = 1'b0;
    assign Sl_toutSup      = 1'b0;
    assign user_data_out   = bit_reverse32(data_q);
    assign user_data_valid = valid_q;

    assign unused_ok = OPB_seqAddr ^ (C_OPB_DWIDTH != OPB_DWIDTH) ^ (C_FAMILY == "");

endmodule

// File: tb/tb_opb_register_ppc2simulink.sv
// Directed bench for opb_register_ppc2simulink with hand-computed expectations.
module tb_opb_register_ppc2simulink;

    logic        clk = 1'b0;
    logic        rst;
    logic [0:31] abus;
    logic [0:3]  be;
    logic [0:31] dbus;
    logic        rnw, sel, seq;
    logic [0:31] sl_dbus;
    logic        sl_ack, sl_err, sl_retry, sl_tout;
    logic [31:0] user_data;
    logic        user_valid;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] s_dbus, s_user;
    logic        s_ack, s_valid, p_ack, p_valid;

    always #5 clk = ~clk;

    opb_register_ppc2simulink #(
        .C_BASEADDR (32'h0000_0000),
        .C_HIGHADDR (32'h0000_00FF),
        .C_DEFAULT  (32'hDEAD_BEEF)
    ) dut (
        .OPB_Clk         (clk),
        .OPB_Rst         (rst),
        .OPB_ABus        (abus),
        .OPB_BE          (be),
        .OPB_DBus        (dbus),
        .OPB_RNW         (rnw),
        .OPB_select      (sel),
        .OPB_seqAddr     (seq),
        .Sl_DBus         (sl_dbus),
        .Sl_xferAck      (sl_ack),
        .Sl_errAck       (sl_err),
        .Sl_retry        (sl_retry),
        .Sl_toutSup      (sl_tout),
        .user_data_out   (user_data),
        .user_data_valid (user_valid)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        sel  = 1'b0;
        rnw  = 1'b1;
        be   = 4'b0000;
        dbus = 32'h0;
        abus = 32'h0;
    endtask

    // Called at a negedge (cycle N); samples N+1 into s_* and N+2 into p_*.
    task automatic xfer(input logic [31:0] addr, input logic [3:0] b,
                        input logic [31:0] wd, input logic r);
        abus = addr; be = b; dbus = wd; rnw = r; sel = 1'b1;
        @(negedge clk);
        s_ack = sl_ack; s_dbus = sl_dbus; s_valid = user_valid; s_user = user_data;
        bus_idle();
        @(negedge clk);
        p_ack = sl_ack; p_valid = user_valid;
    endtask

    initial begin
        int acks;
        logic [31:0] exp_dbus;
        logic exp_ack;

        seq = 1'b0;
        bus_idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ack", {31'b0, sl_ack}, 32'h0);
        chk("rst_dbus", sl_dbus, 32'h0);
        chk("rst_user", user_data, 32'hDEADBEEF);
        chk("rst_valid", {31'b0, user_valid}, 32'h0);
        chk("tied_outs", {29'b0, sl_err, sl_retry, sl_tout}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        xfer(32'h0, 4'b1111, 32'h0, 1'b1);
        chk("rd_def_ack", {31'b0, s_ack}, 32'h1);
        chk("rd_def_data", s_dbus, 32'hDEADBEEF);
        chk("rd_def_valid", {31'b0, s_valid}, 32'h0);
        chk("rd_def_post_ack", {31'b0, p_ack}, 32'h0);

        xfer(32'h0, 4'b1111, 32'h12345678, 1'b0);
        chk("wr_full_ack", {31'b0, s_ack}, 32'h1);
        chk("wr_full_user", s_user, 32'h12345678);
        chk("wr_full_valid", {31'b0, s_valid}, 32'h1);
        chk("wr_full_dbus", s_dbus, 32'h0);
        chk("wr_full_post_valid", {31'b0, p_valid}, 32'h0);

        xfer(32'h0, 4'b0000, 32'h0, 1'b1);
        chk("rd_back", s_dbus, 32'h12345678);
        chk("rd_back_valid", {31'b0, s_valid}, 32'h0);

        xfer(32'h0, 4'b0101, 32'hAABBCCDD, 1'b0);
        chk("wr_be0101_user", s_user, 32'h12BB56DD);
        chk("wr_be0101_valid", {31'b0, s_valid}, 32'h1);

        xfer(32'h0, 4'b0000, 32'hFFFFFFFF, 1'b0);
        chk("wr_be0_ack", {31'b0, s_ack}, 32'h1);
        chk("wr_be0_user", s_user, 32'h12BB56DD);
        chk("wr_be0_valid", {31'b0, s_valid}, 32'h0);

        // Select held: acks only on alternating cycles.
        abus = 32'h0; rnw = 1'b1; sel = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            exp_ack  = (c == 1) || (c == 3);
            exp_dbus = exp_ack ? 32'h12BB56DD : 32'h0;
            chk($sformatf("held_ack_c%0d", c), {31'b0, sl_ack}, {31'b0, exp_ack});
            chk($sformatf("held_dbus_c%0d", c), sl_dbus, exp_dbus);
            if (c == 4) sel = 1'b0;
        end
        bus_idle();
        @(negedge clk);

        // Out of window: never acked.
        abus = 32'h0000_0103; rnw = 1'b1; sel = 1'b1;
        acks = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (sl_ack) acks++;
        end
        chk("oow_acks", acks, 32'd0);
        bus_idle();
        @(negedge clk);

        xfer(32'h10, 4'b1111, 32'h0, 1'b1);
        chk("off10_rd_ack", {31'b0, s_ack}, 32'h1);
        chk("off10_rd_data", s_dbus, 32'h0);

        xfer(32'h10, 4'b1111, 32'hFFFFFFFF, 1'b0);
        chk("off10_wr_ack", {31'b0, s_ack}, 32'h1);
        chk("off10_wr_user", s_user, 32'h12BB56DD);
        chk("off10_wr_valid", {31'b0, s_valid}, 32'h0);

        // Reset arriving during the ACK cycle of a write.
        abus = 32'h0; be = 4'b1111; dbus = 32'hFFFFFFFF; rnw = 1'b0; sel = 1'b1;
        @(negedge clk);
        chk("rstack_ack", {31'b0, sl_ack}, 32'h1);
        chk("rstack_user_pre", user_data, 32'hFFFFFFFF);
        bus_idle();
        rst = 1'b1;
        @(negedge clk);
        chk("rstack_ack_post", {31'b0, sl_ack}, 32'h0);
        chk("rstack_user", user_data, 32'hDEADBEEF);
        chk("rstack_valid", {31'b0, user_valid}, 32'h0);
        chk("rstack_dbus", sl_dbus, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
